main_mem_arb: RTL and testbench

//  Shares the single-port main memory between the etcpu memory-access port (CPU) and a DMA/loader port.

---
 rtl/etcpu_mem_pkg.sv | 20 ++
 rtl/mem_arb_sat_cnt.sv | 28 ++
 rtl/main_mem_arb.sv | 121 ++++++++++++
 tb/tb_main_mem_arb.sv | 461 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/etcpu_mem_pkg.sv
// Shared types and defaults for the main-memory arbiter.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package etcpu_mem_pkg;

    // Port ownership: the CPU owns the port out of reset.
    typedef enum logic {
        CPU_OWN = 1'b0,
        DMA_OWN = 1'b1
    } arb_state_t;

    localparam int unsigned BURST_MAX_DEF    = 16;
    localparam int unsigned DMA_MAX_WAIT_DEF = 8;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear, used for arbiter wait/beat counts.
// Latency: count visible the cycle after an increment or clear.
// Backpressure: none; clear wins over increment, increment at MAX is ignored.
module mem_arb_sat_cnt #(
    parameter int unsigned W   = 4,
    parameter int unsigned MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    // Clear has priority; otherwise count up until the ceiling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != MAX_V)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/main_mem_arb.sv
// Shares the single-port main memory between the CPU port (priority) and a bursting DMA port.
// Latency: mem_* is combinational from the owning port; read data returns 1 cycle after the access.
// Backpressure: CPU held via cpu_stall while DMA owns; DMA waits for dma_gnt, bounded by DMA_MAX_WAIT.
module main_mem_arb
    import etcpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DAT_W        = 32,
    parameter int unsigned BURST_MAX    = BURST_MAX_DEF,
    parameter int unsigned DMA_MAX_WAIT = DMA_MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_cs,
    input  logic              cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DAT_W-1:0]  cpu_dat_in,
    output logic [DAT_W-1:0]  cpu_dat_out,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_wen,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DAT_W-1:0]  dma_dat_in,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic [DAT_W-1:0]  dma_dat_out,
    output logic              dma_rvalid,
    output logic              mem_cs,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DAT_W-1:0]  mem_dat_in,
    input  logic [DAT_W-1:0]  mem_dat_out
);

    if ((BURST_MAX < 1) || (DMA_MAX_WAIT < 1)) begin : g_bad_params
        $error("main_mem_arb: BURST_MAX and DMA_MAX_WAIT must both be >= 1");
    end

    localparam int unsigned        BEAT_W    = cnt_w(BURST_MAX);
    localparam int unsigned        WAIT_W    = cnt_w(DMA_MAX_WAIT + 1);
    localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(BURST_MAX - 1);
    localparam logic [WAIT_W-1:0]  WAIT_SAT  = WAIT_W'(DMA_MAX_WAIT);

    arb_state_t        state;
    logic              rd_dma;
    logic [BEAT_W-1:0] beat_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              dma_beat;
    logic              burst_end;
    logic              grant_dma;

    // A beat is accepted whenever DMA owns the port and asks for it.
    assign dma_beat  = (state == DMA_OWN) && dma_req;
    // Burst ends on the flagged last beat or when the grant's beat allowance is used up.
    assign burst_end = dma_beat && (dma_last || (beat_cnt == BEAT_LAST));
    // CPU keeps the port on a collision until the DMA has waited long enough.
    assign grant_dma = (state == CPU_OWN) && dma_req && (!cpu_cs || (wait_cnt == WAIT_SAT));

    // Cycles the DMA has lost to the CPU; only meaningful while the CPU owns the port.
    mem_arb_sat_cnt #(
        .W   (WAIT_W),
        .MAX (DMA_MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state != CPU_OWN) || !dma_req || grant_dma),
        .inc   (dma_req && cpu_cs),
        .cnt   (wait_cnt)
    );

    // Beats accepted under the current grant; zero whenever the CPU owns the port.
    mem_arb_sat_cnt #(
        .W   (BEAT_W),
        .MAX (BURST_MAX - 1)
    ) u_beat_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   ((state != DMA_OWN) || !dma_req || burst_end),
        .inc   (dma_beat),
        .cnt   (beat_cnt)
    );

    // Ownership FSM and DMA read-return flag. Every release lands in CPU_OWN for at
    // least one cycle, since a re-grant is only decided from CPU_OWN and takes effect next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= CPU_OWN;
            rd_dma <= 1'b0;
        end else begin
            rd_dma <= dma_beat && !dma_wen;
            case (state)
                CPU_OWN: if (grant_dma) state <= DMA_OWN;
                DMA_OWN: if (!dma_req || burst_end) state <= CPU_OWN;
                default: state <= CPU_OWN;
            endcase
        end
    end

    // Port mux: the owner drives the memory; a CPU request during DMA ownership is held off.
    always_comb begin
        mem_cs     = cpu_cs;
        mem_wen    = cpu_wen;
        mem_addr   = cpu_addr;
        mem_dat_in = cpu_dat_in;
        cpu_stall  = 1'b0;
        if (state == DMA_OWN) begin
            mem_cs     = dma_req;
            mem_wen    = dma_wen;
            mem_addr   = dma_addr;
            mem_dat_in = dma_dat_in;
            cpu_stall  = cpu_cs;
        end
    end

    assign dma_gnt     = (state == DMA_OWN);
    assign dma_rvalid  = rd_dma;
    assign dma_dat_out = mem_dat_out;
    // The CPU only samples this after its own accepted read, so no qualifier is needed.
    assign cpu_dat_out = mem_dat_out;

endmodule

// File: tb/tb_main_mem_arb.sv
// Self-checking bench for main_mem_arb: directed ownership scenarios plus randomized traffic.
// Latency: a behavioural memory answers reads one cycle after the access.
// Backpressure: CPU agent holds while stalled, DMA agent holds each beat until granted.
module tb_main_mem_arb;

    localparam int BMAX = 16;
    localparam int MAXW = 8;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        cpu_cs      = 1'b0;
    logic        cpu_wen     = 1'b0;
    logic [31:0] cpu_addr    = '0;
    logic [31:0] cpu_dat_in  = '0;
    logic [31:0] cpu_dat_out;
    logic        cpu_stall;
    logic        dma_req     = 1'b0;
    logic        dma_wen     = 1'b0;
    logic [31:0] dma_addr    = '0;
    logic [31:0] dma_dat_in  = '0;
    logic        dma_last    = 1'b0;
    logic        dma_gnt;
    logic [31:0] dma_dat_out;
    logic        dma_rvalid;
    logic        mem_cs;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_dat_in;
    logic [31:0] mem_dat_out = '0;

    always #5 clk = ~clk;

    main_mem_arb #(
        .ADDR_W       (32),
        .DAT_W        (32),
        .BURST_MAX    (BMAX),
        .DMA_MAX_WAIT (MAXW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_cs      (cpu_cs),
        .cpu_wen     (cpu_wen),
        .cpu_addr    (cpu_addr),
        .cpu_dat_in  (cpu_dat_in),
        .cpu_dat_out (cpu_dat_out),
        .cpu_stall   (cpu_stall),
        .dma_req     (dma_req),
        .dma_wen     (dma_wen),
        .dma_addr    (dma_addr),
        .dma_dat_in  (dma_dat_in),
        .dma_last    (dma_last),
        .dma_gnt     (dma_gnt),
        .dma_dat_out (dma_dat_out),
        .dma_rvalid  (dma_rvalid),
        .mem_cs      (mem_cs),
        .mem_wen     (mem_wen),
        .mem_addr    (mem_addr),
        .mem_dat_in  (mem_dat_in),
        .mem_dat_out (mem_dat_out)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input logic [9:0] i);
        return 32'hA500_0000 | {22'd0, i};
    endfunction

    // Behavioural synchronous-read memory macro.
    logic [31:0] tmem  [0:1023];
    bit          tm_wr [0:1023];
    always @(posedge clk) begin
        if (mem_cs === 1'b1) begin
            if (mem_wen) begin
                tmem[mem_addr[11:2]]  <= mem_dat_in;
                tm_wr[mem_addr[11:2]] <= 1'b1;
            end else begin
                mem_dat_out <= tm_wr[mem_addr[11:2]] ? tmem[mem_addr[11:2]] : init_word(mem_addr[11:2]);
            end
        end
    end

    // Reference memory contents, updated in acceptance order.
    logic [31:0] shadow [0:1023];
    bit          sh_wr  [0:1023];
    function automatic logic [31:0] sh_read(input logic [31:0] a);
        return sh_wr[a[11:2]] ? shadow[a[11:2]] : init_word(a[11:2]);
    endfunction

    typedef struct { int due; logic [31:0] d; } rd_t;
    typedef struct { int due; logic [31:0] a; logic [31:0] d; } wr_t;
    rd_t cq[$];
    rd_t dq[$];
    wr_t wq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_max(input string name, input int act, input int lim);
        n_cmp++;
        if (act > lim) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0d, limit %0d", name, cyc, act, lim);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a write, a DMA return or a CPU return.
    initial begin
        rd_t r;
        wr_t w;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (dma_rvalid !== 1'b0) begin
                if (dq.size() == 0) begin
                    chk("dma_rvalid_spurious", dma_rvalid, 1'b0);
                end else begin
                    r = dq.pop_front();
                    chk("dma_rvalid_cycle", cyc, r.due);
                    chk("dma_rdata", dma_dat_out, r.d);
                end
            end else if (dq.size() > 0 && dq[0].due <= cyc) begin
                r = dq.pop_front();
                chk("dma_rvalid_missing", dma_rvalid, 1'b1);
            end
            if (cq.size() > 0 && cq[0].due <= cyc) begin
                r = cq.pop_front();
                chk("cpu_rdata_cycle", cyc, r.due);
                chk("cpu_rdata", cpu_dat_out, r.d);
            end
            if (mem_cs === 1'b1 && mem_wen === 1'b1) begin
                if (wq.size() == 0) begin
                    chk("mem_wr_spurious", mem_wen, 1'b0);
                end else begin
                    w = wq.pop_front();
                    chk("mem_wr_cycle", cyc, w.due);
                    chk("mem_wr_addr", mem_addr, w.a);
                    chk("mem_wr_data", mem_dat_in, w.d);
                end
            end else if (wq.size() > 0 && wq[0].due <= cyc) begin
                w = wq.pop_front();
                chk("mem_wr_missing", mem_wen, 1'b1);
            end
        end
    end

    bit g_dma_acc;
    bit g_cpu_acc;
    bit prev_last_acc = 1'b0;

    // Sample handshakes mid-cycle and record the expected effect of every accepted access.
    task automatic settle();
        rd_t r;
        wr_t w;
        #1;
        g_dma_acc = (dma_req === 1'b1) && (dma_gnt === 1'b1);
        g_cpu_acc = (cpu_cs === 1'b1) && (cpu_stall === 1'b0);
        if (cpu_cs && dma_req) chk("one_owner", {62'd0, g_cpu_acc, g_dma_acc} == 64'd3, 1'b0);
        if (prev_last_acc) chk("release_after_last", dma_gnt, 1'b0);
        prev_last_acc = g_dma_acc && dma_last && rst_n;
        if (g_dma_acc) begin
            if (dma_wen) begin
                shadow[dma_addr[11:2]] = dma_dat_in;
                sh_wr[dma_addr[11:2]]  = 1'b1;
                w.due = cyc; w.a = dma_addr; w.d = dma_dat_in;
                wq.push_back(w);
            end else if (rst_n) begin
                r.due = cyc + 1; r.d = sh_read(dma_addr);
                dq.push_back(r);
            end
        end
        if (g_cpu_acc) begin
            if (cpu_wen) begin
                shadow[cpu_addr[11:2]] = cpu_dat_in;
                sh_wr[cpu_addr[11:2]]  = 1'b1;
                w.due = cyc; w.a = cpu_addr; w.d = cpu_dat_in;
                wq.push_back(w);
            end else begin
                r.due = cyc + 1; r.d = sh_read(cpu_addr);
                cq.push_back(r);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            adv();
        end
    endtask

    int   req_cyc;
    int   acc_cyc[$];
    logic gnt_q[$];
    logic stall_q[$];

    // One DMA burst of n beats from base; logs grant/stall per cycle and acceptance cycles.
    task automatic dma_burst(input bit wen, input logic [31:0] base, input int n, input bit use_last);
        int beat  = 0;
        int guard = 0;
        bit acc;
        acc_cyc.delete();
        gnt_q.delete();
        stall_q.delete();
        req_cyc    = cyc;
        dma_req    = 1'b1;
        dma_wen    = wen;
        dma_addr   = base;
        dma_dat_in = $urandom;
        dma_last   = use_last && (n == 1);
        while (beat < n && guard < 200) begin
            settle();
            gnt_q.push_back(dma_gnt);
            stall_q.push_back(cpu_stall);
            acc = g_dma_acc;
            if (acc) acc_cyc.push_back(cyc);
            guard++;
            adv();
            if (acc) begin
                beat++;
                dma_addr   = base + 32'(4 * beat);
                dma_dat_in = $urandom;
                dma_last   = use_last && (beat == n - 1);
                if (beat == n) dma_req = 1'b0;
            end
        end
        chk_max("dma_burst_timeout", n - beat, 0);
        dma_req  = 1'b0;
        dma_last = 1'b0;
    endtask

    task automatic cpu_op(input bit wen, input logic [31:0] a, input logic [31:0] d);
        int guard = 0;
        bit ok    = 1'b0;
        cpu_cs     = 1'b1;
        cpu_wen    = wen;
        cpu_addr   = a;
        cpu_dat_in = d;
        while (!ok && guard < 50) begin
            settle();
            ok = g_cpu_acc;
            guard++;
            adv();
        end
        chk("cpu_op_accepted", ok, 1'b1);
        cpu_cs = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int  beat;
        int  guard;
        bit  acc;
        bit  cacc;
        bit  dacc;
        int  stretch;
        int  bbeats;
        int  d_n;
        int  d_beat;
        int  d_idle;
        bit  d_use;
        logic [31:0] d_base;

        // T1: reset with both requesters active.
        rst_n    = 1'b0;
        dma_req  = 1'b1;
        cpu_cs   = 1'b1;
        cpu_wen  = 1'b0;
        cpu_addr = 32'h10;
        adv();
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("rst_gnt", dma_gnt, 1'b0);
            chk("rst_stall", cpu_stall, 1'b0);
            chk("rst_mem_cs", mem_cs, 1'b1);
            chk("rst_mem_addr", mem_addr, 32'h10);
            chk("rst_rvalid", dma_rvalid, 1'b0);
            adv();
        end
        rst_n   = 1'b1;
        dma_req = 1'b0;
        cpu_cs  = 1'b0;
        idle(2);

        // T2: idle CPU, 4-beat DMA write burst.
        dma_burst(1'b1, 32'h100, 4, 1'b1);
        chk("t2_beats", acc_cyc.size(), 4);
        chk("t2_no_gnt_first", gnt_q[0], 1'b0);
        if (acc_cyc.size() == 4) begin
            chk("t2_first_beat", acc_cyc[0], req_cyc + 1);
            chk("t2_last_beat", acc_cyc[3], req_cyc + 4);
        end
        settle();
        chk("t2_gnt_after_last", dma_gnt, 1'b0);
        adv();
        idle(2);

        // T3: CPU busy every cycle; DMA must win after DMA_MAX_WAIT losses.
        cpu_cs   = 1'b1;
        cpu_wen  = 1'b0;
        cpu_addr = 32'h200;
        dma_burst(1'b1, 32'h300, 2, 1'b1);
        chk("t3_beats", acc_cyc.size(), 2);
        if (acc_cyc.size() == 2) chk("t3_grant_delay", acc_cyc[0] - req_cyc, MAXW + 1);
        for (int k = 0; k < gnt_q.size(); k++) begin
            chk("t3_gnt", gnt_q[k], k >= MAXW + 1);
            chk("t3_stall", stall_q[k], k >= MAXW + 1);
        end
        cpu_cs = 1'b0;
        idle(3);

        // T4: 20 beats with no last flag; forced release after BMAX beats.
        dma_burst(1'b1, 32'h400, 20, 1'b0);
        chk("t4_beats", acc_cyc.size(), 20);
        if (acc_cyc.size() == 20) begin
            for (int b = 0; b < 20; b++)
                chk("t4_beat_cycle", acc_cyc[b] - req_cyc, (b < BMAX) ? b + 1 : b + 2);
        end
        for (int k = 0; k < gnt_q.size(); k++)
            chk("t4_gnt", gnt_q[k], (k >= 1) && (k != BMAX + 1));
        idle(2);
        dma_burst(1'b0, 32'h400, 16, 1'b1);
        idle(3);

        // T5: single DMA read of a known word.
        cpu_op(1'b1, 32'h40, 32'hDEAD_BEEF);
        idle(1);
        dma_burst(1'b0, 32'h40, 1, 1'b1);
        chk("t5_beats", acc_cyc.size(), 1);
        idle(3);

        // T6: reset asserted after beat 2 of a read burst.
        dma_req  = 1'b1;
        dma_wen  = 1'b0;
        dma_addr = 32'h100;
        dma_last = 1'b0;
        beat     = 0;
        guard    = 0;
        while (beat < 2 && guard < 50) begin
            settle();
            acc = g_dma_acc;
            guard++;
            adv();
            if (acc) begin
                beat++;
                dma_addr = 32'h100 + 32'(4 * beat);
            end
        end
        chk("t6_two_beats", beat, 2);
        rst_n    = 1'b0;
        cpu_cs   = 1'b1;
        cpu_wen  = 1'b0;
        cpu_addr = 32'h500;
        settle();
        adv();
        rst_n   = 1'b1;
        dma_req = 1'b0;
        settle();
        chk("t6_gnt", dma_gnt, 1'b0);
        chk("t6_rvalid", dma_rvalid, 1'b0);
        chk("t6_mem_cs", mem_cs, 1'b1);
        chk("t6_mem_wen", mem_wen, 1'b0);
        chk("t6_mem_addr", mem_addr, 32'h500);
        adv();
        cpu_cs = 1'b0;
        idle(3);

        // Random mixed traffic with fairness and burst-length bounds.
        stretch = 0;
        bbeats  = 0;
        d_idle  = 0;
        d_n     = 0;
        d_beat  = 0;
        d_use   = 1'b0;
        d_base  = '0;
        for (int t = 0; t < 3000; t++) begin
            settle();
            if (dma_req && !dma_gnt) begin
                stretch++;
            end else begin
                if (stretch > 0) chk_max("dma_wait", stretch, MAXW + 1);
                stretch = 0;
            end
            if (dma_gnt) begin
                if (g_dma_acc) bbeats++;
            end else begin
                if (bbeats > 0) chk_max("burst_len", bbeats, BMAX);
                bbeats = 0;
            end
            cacc = g_cpu_acc;
            dacc = g_dma_acc;
            adv();
            if (!cpu_cs || cacc) begin
                if ($urandom_range(99) < 60) begin
                    cpu_cs     = 1'b1;
                    cpu_wen    = 1'($urandom_range(1));
                    cpu_addr   = 32'h800 + 32'(4 * $urandom_range(15));
                    cpu_dat_in = $urandom;
                end else begin
                    cpu_cs = 1'b0;
                end
            end
            if (dma_req && dacc) begin
                d_beat++;
                if (d_beat == d_n) begin
                    dma_req  = 1'b0;
                    dma_last = 1'b0;
                    d_idle   = $urandom_range(6);
                end else begin
                    dma_addr   = d_base + 32'(4 * d_beat);
                    dma_dat_in = $urandom;
                    dma_last   = d_use && (d_beat == d_n - 1);
                end
            end else if (!dma_req) begin
                if (d_idle > 0) begin
                    d_idle--;
                end else begin
                    d_n        = $urandom_range(20, 1);
                    d_beat     = 0;
                    d_use      = 1'($urandom_range(1));
                    d_base     = 32'h800 + 32'(4 * $urandom_range(15));
                    dma_req    = 1'b1;
                    dma_wen    = 1'($urandom_range(1));
                    dma_addr   = d_base;
                    dma_dat_in = $urandom;
                    dma_last   = d_use && (d_n == 1);
                end
            end
        end
        dma_req  = 1'b0;
        dma_last = 1'b0;
        cpu_cs   = 1'b0;
        idle(4);

        chk("cpu_q_drained", cq.size(), 0);
        chk("dma_q_drained", dq.size(), 0);
        chk("wr_q_drained", wq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
